fetch: RTL
==========

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter PC_W, default 14, width of the bundle (64-bit word) address.
REQ-002 Parameter RESET_PC, default 0, first bundle address fetched after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 interlock  input  1  hazard hold from the interlock unit; decode does not accept inst this cycle.
REQ-006 decode_stall  input  1  decode-stage stall; decode does not accept inst this cycle.
REQ-007 redirect_valid  input  1  taken branch/jump resolved downstream; flush and refetch.
REQ-008 redirect_pc  input  PC_W  target bundle address, sampled when redirect_valid=1.
REQ-009 imem_addr  output  PC_W  instruction memory read address; equals issue_pc register.
REQ-010 imem_rdata  input  64  instruction memory data; fixed 1-cycle read latency; memory has no enable and reads every cycle.
REQ-011 inst  output  64  bundle to decode {upper[63:32], lower[31:0]}; NOP_BUNDLE = {3'b111,29'b0,3'b111,29'b0} when invalid.
REQ-012 inst_pc  output  PC_W  address of the bundle on inst.
REQ-013 inst_valid  output  1  inst holds a real fetched bundle.
REQ-014 fetch_count  output  32  number of valid bundles accepted by decode.

Function
REQ-015 hold = interlock | decode_stall; decode accepts inst on a posedge where hold=0.
REQ-016 Registers: issue_pc, rsp_pc, rsp_valid (tracks the read in flight), skid buffer buf/buf_pc/buf_valid, state in {RUN, STALL}.
REQ-017 RUN output: inst = rsp_valid ? imem_rdata : NOP_BUNDLE; inst_pc = rsp_pc; inst_valid = rsp_valid.
REQ-018 STALL output: inst = buf_valid ? buf : NOP_BUNDLE; inst_pc = buf_pc; inst_valid = buf_valid.
REQ-019 redirect_valid=1 forces inst = NOP_BUNDLE, inst_valid = 0 combinationally in the same cycle (wrong-path squash).
REQ-020 Priority per cycle: redirect > hold > advance.
REQ-021 Redirect (any state): issue_pc <= redirect_pc; rsp_valid <= 0; buf_valid <= 0; state <= RUN.
REQ-022 RUN with hold: buf <= inst; buf_pc <= rsp_pc; buf_valid <= rsp_valid; issue_pc, rsp_pc unchanged; rsp_valid <= 0; state <= STALL.
REQ-023 STALL with hold: all registers unchanged; imem_addr stays at issue_pc.
REQ-024 Advance (RUN or STALL, no hold): rsp_pc <= issue_pc; rsp_valid <= 1; issue_pc <= issue_pc + 1 (mod 2^PC_W, wrap silent); buf_valid <= 0; state <= RUN.
REQ-025 No bundle is dropped or duplicated across any hold length >= 1 cycle.
REQ-026 Redirect latency: redirect at cycle N -> NOP at N+1, bundle at redirect_pc with inst_valid=1 at N+2 if hold=0.
REQ-027 Redirect during hold takes effect; redirect on the cycle hold deasserts discards buf.
REQ-028 fetch_count increments by 1 on each posedge with inst_valid=1 and hold=0; wraps at 2^32.

Reset
REQ-029 While rstn=0: issue_pc=RESET_PC, rsp_pc=0, rsp_valid=0, buf=NOP_BUNDLE, buf_pc=0, buf_valid=0, state=RUN, fetch_count=0.
REQ-030 Resulting outputs in reset: imem_addr=RESET_PC, inst=NOP_BUNDLE, inst_pc=0, inst_valid=0.
REQ-031 First valid bundle (RESET_PC) appears on inst 1 cycle after rstn deasserts, given hold=0.
REQ-032 Reset mid-stall discards buf immediately (asynchronous).

Structure
REQ-033 Shared package holds NOP_BUNDLE, fetch_state_t {RUN, STALL}, and PC_W default.
REQ-034 One sub-module, fetch_skid: one-entry 64+PC_W+1-bit skid register with load/clear controls.

Verification
REQ-035 Reset release, hold=0, imem returns addr-tagged data -> inst_pc 0,1,2,3 on consecutive cycles, inst_valid=1 from cycle 1.
REQ-036 hold=1 for 3 cycles while inst_pc=5 -> inst_pc=5 for all 4 cycles, then 6; fetch_count counts 5 exactly once.
REQ-037 redirect_valid=1, redirect_pc=0x100 at cycle N -> inst=NOP at N and N+1, inst_pc=0x100 valid at N+2.
REQ-038 Redirect asserted during second STALL cycle -> buf discarded, state RUN, target bundle at +2 cycles.
REQ-039 issue_pc = 2^PC_W-1 advancing -> next inst_pc=0, no error.
REQ-040 rstn low during STALL -> outputs match REQ-030 within the same cycle, fetch_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;

   localparam int PC_W_DEF = 14;

   localparam logic [63:0] NOP_BUNDLE = {3'b111, 29'b0, 3'b111, 29'b0};

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: decode handshake, redirect, instruction memory and status.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
);
   logic            interlock;
   logic            decode_stall;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic [PC_W-1:0] imem_addr;
   logic [63:0]     imem_rdata;
   logic [63:0]     inst;
   logic [PC_W-1:0] inst_pc;
   logic            inst_valid;
   logic [31:0]     fetch_count;

   modport slave (
      input  interlock, decode_stall, redirect_valid, redirect_pc, imem_rdata,
      output imem_addr, inst, inst_pc, inst_valid, fetch_count
   );

   modport master (
      output interlock, decode_stall, redirect_valid, redirect_pc, imem_rdata,
      input  imem_addr, inst, inst_pc, inst_valid, fetch_count
   );
endinterface

// File: rtl/fetch_skid.sv
// One-entry skid register holding the bundle presented when decode stalled.
module fetch_skid
   import fetch_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic [63:0]     i_data,
   input  logic [PC_W-1:0] i_pc,
   input  logic            i_valid,
   output logic [63:0]     o_data,
   output logic [PC_W-1:0] o_pc,
   output logic            o_valid
);
   logic [63:0]     r_data;
   logic [PC_W-1:0] r_pc;
   logic            r_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_data  <= NOP_BUNDLE;
         r_pc    <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_pc    <= i_pc;
         r_valid <= i_valid;
      end
   end

   assign o_data  = r_data;
   assign o_pc    = r_pc;
   assign o_valid = r_valid;
endmodule

// File: rtl/fetch.sv
// Instruction fetch: one read in flight, skid buffer across decode holds.
//   state | meaning
//   RUN   | inst comes straight from the in-flight memory read
//   STALL | decode is holding; inst replays the skid buffer
module fetch
   import fetch_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic     clk,
   input logic     rstn,
   fetch_if.slave  bus
);
   fetch_state_t    r_state, w_state_nxt;
   logic [PC_W-1:0] r_issue_pc, w_issue_pc_nxt;
   logic [PC_W-1:0] r_rsp_pc, w_rsp_pc_nxt;
   logic            r_rsp_valid, w_rsp_valid_nxt;
   logic [31:0]     r_fetch_count;

   logic            w_hold;
   logic            w_skid_load;
   logic            w_skid_clear;
   logic [63:0]     w_buf_data;
   logic [PC_W-1:0] w_buf_pc;
   logic            w_buf_valid;
   logic [63:0]     w_raw_inst;
   logic [PC_W-1:0] w_raw_pc;
   logic            w_raw_valid;
   logic [63:0]     w_inst;
   logic            w_inst_valid;

   assign w_hold = bus.interlock | bus.decode_stall;

   fetch_skid #(.PC_W(PC_W)) u_skid (
      .clk     (clk),
      .rstn    (rstn),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_data  (w_raw_inst),
      .i_pc    (r_rsp_pc),
      .i_valid (r_rsp_valid),
      .o_data  (w_buf_data),
      .o_pc    (w_buf_pc),
      .o_valid (w_buf_valid)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= RUN;
         r_issue_pc  <= RESET_PC;
         r_rsp_pc    <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_issue_pc  <= w_issue_pc_nxt;
         r_rsp_pc    <= w_rsp_pc_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
      end
   end

   // Redirect wins over hold, hold wins over advance.
   always_comb begin
      w_state_nxt     = r_state;
      w_issue_pc_nxt  = r_issue_pc;
      w_rsp_pc_nxt    = r_rsp_pc;
      w_rsp_valid_nxt = r_rsp_valid;
      w_skid_load     = 1'b0;
      w_skid_clear    = 1'b0;
      if (bus.redirect_valid) begin
         w_issue_pc_nxt  = bus.redirect_pc;
         w_rsp_valid_nxt = 1'b0;
         w_skid_clear    = 1'b1;
         w_state_nxt     = RUN;
      end else if (w_hold) begin
         if (r_state == RUN) begin
            w_skid_load     = 1'b1;
            w_rsp_valid_nxt = 1'b0;
            w_state_nxt     = STALL;
         end
      end else begin
         w_rsp_pc_nxt    = r_issue_pc;
         w_rsp_valid_nxt = 1'b1;
         w_issue_pc_nxt  = r_issue_pc + PC_W'(1);
         w_skid_clear    = 1'b1;
         w_state_nxt     = RUN;
      end
   end

   always_comb begin
      w_raw_inst  = NOP_BUNDLE;
      w_raw_pc    = r_rsp_pc;
      w_raw_valid = 1'b0;
      if (r_state == RUN) begin
         w_raw_inst  = r_rsp_valid ? bus.imem_rdata : NOP_BUNDLE;
         w_raw_pc    = r_rsp_pc;
         w_raw_valid = r_rsp_valid;
      end else begin
         w_raw_inst  = w_buf_valid ? w_buf_data : NOP_BUNDLE;
         w_raw_pc    = w_buf_pc;
         w_raw_valid = w_buf_valid;
      end
   end

   // A resolved redirect means the bundle on inst is wrong-path.
   assign w_inst       = bus.redirect_valid ? NOP_BUNDLE : w_raw_inst;
   assign w_inst_valid = w_raw_valid & ~bus.redirect_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_fetch_count <= '0;
      end else if (w_inst_valid && !w_hold) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign bus.imem_addr   = r_issue_pc;
   assign bus.inst        = w_inst;
   assign bus.inst_pc     = w_raw_pc;
   assign bus.inst_valid  = w_inst_valid;
   assign bus.fetch_count = r_fetch_count;
endmodule
